// File: rtl/alu_dispatch.sv
// Decoded-instruction dispatcher: latches operands and ALU control, waits one EXEC cycle, holds the result until consumed.
// Optional feature: define ALU_DISPATCH_BRANCH_EN to decode BRANCH opcodes (otherwise they are illegal).
module alu_dispatch #(
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  output logic [31:0] Op1,
  output logic [31:0] Op2,
  output logic [3:0]  Alu_Control,
  input  logic [31:0] Alu_Result,
  input  logic        Zero_f,
  input  logic        Sign_f,
  input  logic        branch_u,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_branch_taken,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [31:0] dec_op2;
  logic [3:0]  dec_ctrl;
  logic        dec_illegal;
  logic        dec_branch;
  logic        cls_illegal;
  logic        cls_branch;
  logic [2:0]  cls_funct3;
  logic        taken;
  logic        unused_flags;

  // Instruction decode
  always_comb begin
    dec_op2     = in_rs2_val;
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        dec_ctrl    = {in_funct3, in_funct7_5};
        dec_illegal = in_funct7_5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      end
      OPC_OP_IMM: begin
        dec_op2     = in_imm;
        dec_ctrl    = {in_funct3, (in_funct3 == 3'b101) ? in_funct7_5 : 1'b0};
        dec_illegal = (in_funct3 == 3'b001) && in_funct7_5;
      end
`ifdef ALU_DISPATCH_BRANCH_EN
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        case (in_funct3[2:1])
          2'b00:   dec_ctrl = 4'b0001;
          2'b10:   dec_ctrl = 4'b0100;
          2'b11:   dec_ctrl = 4'b0110;
          default: dec_illegal = 1'b1;
        endcase
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl   = '0;
      dec_branch = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXEC;
               else if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

`ifdef ALU_DISPATCH_BRANCH_EN
  // funct3[0] inverts the sense of each compare (BNE/BGE/BGEU)
  always_comb begin
    taken = 1'b0;
    if (cls_branch) begin
      case (cls_funct3[2:1])
        2'b00:   taken = Zero_f ^ cls_funct3[0];
        2'b10:   taken = Alu_Result[0] ^ cls_funct3[0];
        2'b11:   taken = branch_u ^ cls_funct3[0];
        default: taken = 1'b0;
      endcase
    end
  end
  assign unused_flags = Sign_f;
`else
  assign taken        = 1'b0;
  assign unused_flags = ^{Sign_f, Zero_f, branch_u, cls_branch, cls_funct3};
`endif

  // Operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Op1              <= '0;
      Op2              <= '0;
      Alu_Control      <= '0;
      cls_illegal      <= 1'b0;
      cls_branch       <= 1'b0;
      cls_funct3       <= '0;
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else begin
      if (accept) begin
        Op1         <= in_rs1_val;
        Op2         <= dec_op2;
        Alu_Control <= dec_ctrl;
        cls_illegal <= dec_illegal;
        cls_branch  <= dec_branch;
        cls_funct3  <= in_funct3;
      end
      if (state == EXEC) begin
        out_valid        <= 1'b1;
        out_result       <= cls_illegal ? ILLEGAL_RESULT : Alu_Result;
        out_illegal      <= cls_illegal;
        out_branch_taken <= taken;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed scenarios plus randomized instructions against a reference model.
module tb_alu_dispatch;

  localparam logic [31:0] ILL = 32'hDEAD_BEEF;
  localparam logic [6:0]  OP = 7'b0110011, OPI = 7'b0010011, BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic [31:0] Op1, Op2;
  logic [3:0]  Alu_Control;
  logic [31:0] Alu_Result;
  logic        Zero_f, Sign_f, branch_u;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_branch_taken, out_illegal;

  int unsigned n_pass = 0, n_total = 0;

  typedef struct {
    logic        ill;
    logic [31:0] res;
    logic        tk;
    logic [3:0]  ctrl;
    logic [31:0] op2;
  } exp_t;

  exp_t exp_g;

  always #5 clk = ~clk;

  alu_dispatch #(.ILLEGAL_RESULT(ILL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .Op1(Op1), .Op2(Op2), .Alu_Control(Alu_Control), .Alu_Result(Alu_Result),
    .Zero_f(Zero_f), .Sign_f(Sign_f), .branch_u(branch_u),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
  );

  // Environment ALU driven by the DUT's registered operands
  always_comb begin
    case (Alu_Control[3:1])
      3'd0:    Alu_Result = Alu_Control[0] ? Op1 - Op2 : Op1 + Op2;
      3'd1:    Alu_Result = Op1 << Op2[4:0];
      3'd2:    Alu_Result = {31'd0, $signed(Op1) < $signed(Op2)};
      3'd3:    Alu_Result = {31'd0, Op1 < Op2};
      3'd4:    Alu_Result = Op1 ^ Op2;
      3'd5:    Alu_Result = Alu_Control[0] ? $unsigned($signed(Op1) >>> Op2[4:0]) : Op1 >> Op2[4:0];
      3'd6:    Alu_Result = Op1 | Op2;
      default: Alu_Result = Op1 & Op2;
    endcase
    Zero_f   = (Alu_Result == 32'd0);
    Sign_f   = Alu_Result[31];
    branch_u = (Op1 < Op2);
  end

  // Architectural reference: what each instruction means, not how it is dispatched
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    exp_t e;
    logic [4:0] sh;
    e = '{ill: 1'b0, res: 32'd0, tk: 1'b0, ctrl: 4'd0, op2: b};
    if (opc == OP) begin
      sh = b[4:0];
      e.ctrl = {f3, f7};
      if (f7 && f3 != 3'd0 && f3 != 3'd5) e.ill = 1'b1;
      case (f3)
        3'd0: e.res = f7 ? a - b : a + b;
        3'd1: e.res = a << sh;
        3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ b;
        3'd5: e.res = f7 ? $unsigned($signed(a) >>> sh) : a >> sh;
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end else if (opc == OPI) begin
      sh = imm[4:0];
      e.op2 = imm;
      e.ctrl = {f3, (f3 == 3'd5) ? f7 : 1'b0};
      if (f3 == 3'd1 && f7) e.ill = 1'b1;
      case (f3)
        3'd0: e.res = a + imm;
        3'd1: e.res = a << sh;
        3'd2: e.res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: e.res = (a < imm) ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ imm;
        3'd5: e.res = f7 ? $unsigned($signed(a) >>> sh) : a >> sh;
        3'd6: e.res = a | imm;
        default: e.res = a & imm;
      endcase
`ifdef ALU_DISPATCH_BRANCH_EN
    end else if (opc == BR) begin
      case (f3)
        3'd0: begin e.ctrl = 4'b0001; e.res = a - b; e.tk = (a == b); end
        3'd1: begin e.ctrl = 4'b0001; e.res = a - b; e.tk = (a != b); end
        3'd4: begin e.ctrl = 4'b0100; e.tk = ($signed(a) < $signed(b)); e.res = {31'd0, e.tk}; end
        3'd5: begin e.ctrl = 4'b0100; e.tk = !($signed(a) < $signed(b)); e.res = {31'd0, !e.tk}; end
        3'd6: begin e.ctrl = 4'b0110; e.tk = (a < b); e.res = {31'd0, e.tk}; end
        3'd7: begin e.ctrl = 4'b0110; e.tk = !(a < b); e.res = {31'd0, !e.tk}; end
        default: e.ill = 1'b1;
      endcase
`endif
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.res = ILL;
      e.tk = 1'b0;
      e.ctrl = 4'd0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Called at a negedge: offers one instruction, checks the EXEC cycle and the result cycle
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    exp_g = model(opc, f3, f7, a, b, imm);
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
    in_rs1_val = a; in_rs2_val = b; in_imm = imm;
    #1 check("in_ready_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_rs1_val = $urandom; in_rs2_val = $urandom; in_imm = $urandom;
    check("exec_out_valid", {31'd0, out_valid}, 32'd0);
    check("alu_control", {28'd0, Alu_Control}, {28'd0, exp_g.ctrl});
    if (!exp_g.ill) begin
      check("op1", Op1, a);
      check("op2", Op2, exp_g.op2);
    end
    @(posedge clk); #1;
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_result", out_result, exp_g.res);
    check("out_branch_taken", {31'd0, out_branch_taken}, {31'd0, exp_g.tk});
    check("out_illegal", {31'd0, out_illegal}, {31'd0, exp_g.ill});
  endtask

  task automatic drain();
    @(posedge clk); #1;
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a, b, imm;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_taken", {31'd0, out_branch_taken}, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_op1", Op1, 32'd0);
    check("rst_op2", Op2, 32'd0);
    check("rst_ctrl", {28'd0, Alu_Control}, 32'd0);

    // First accept on the first edge after release
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    send(OP, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
    check("add_5_7", out_result, 32'd12);
    drain();

    send(OPI, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404);
    check("srai_result", out_result, 32'hF800_0000);
    drain();

    send(BR, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    drain();
    send(BR, 3'b111, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    drain();

    send(7'b0000011, 3'b010, 1'b0, 32'd3, 32'd4, 32'd8);
    check("load_illegal", {31'd0, out_illegal}, 32'd1);
    check("load_result", out_result, ILL);
    drain();

    // Consumer stall, then back-to-back accept on the releasing edge
    out_ready = 1'b0;
    send(OP, 3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result", out_result, 32'h00F0_1200);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(OP, 3'b000, 1'b1, 32'd100, 32'd1, 32'd0);
    drain();

    // Reset while EXEC discards the instruction
    @(negedge clk);
    in_valid = 1'b1; in_opcode = OP; in_funct3 = 3'b000; in_funct7_5 = 1'b0;
    in_rs1_val = 32'd9; in_rs2_val = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_op1", Op1, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);

    for (int unsigned i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      imm = $urandom;
      imm = {{20{imm[11]}}, imm[11:0]};
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin opc = OP; f7 = ($urandom_range(0, 3) == 0); end
        1: begin opc = OPI; f7 = imm[10]; end
        2: begin opc = BR; f7 = 1'($urandom_range(0, 1)); if ($urandom_range(0, 3) == 0) b = a; end
        default: begin opc = 7'($urandom_range(0, 127)); f7 = 1'($urandom_range(0, 1)); end
      endcase
      send(opc, f3, f7, a, b, imm);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
